assoc_cache_ctrl: RTL and testbench
===================================

ASSOC_CACHE_CTRL -- requirements
Module: assoc_cache_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the byte-address width.
REQ-002 The block SHALL have parameter WORD_W, default 32, meaning the CPU data word width; a cache block SHALL be 2*WORD_W.
REQ-003 The block SHALL have parameter INDEX_W, default 6, meaning the set-index width (64 sets × 2 ways); TAG_W SHALL equal ADDR_W-3-INDEX_W.
REQ-004 The block SHALL have port clk, input, 1, the clock, rising-edge.
REQ-005 The block SHALL have port rst, input, 1, the reset, asynchronous, active-high.
REQ-006 The block SHALL have ports rd_en and wr_en, each input, 1, the CPU read and write requests.
REQ-007 The block SHALL have ports addr, input, ADDR_W, and wdata, input, WORD_W, the CPU byte address and write data.
REQ-008 The block SHALL have ports rdata, output, WORD_W, and ready, output, 1, the CPU read data and request-complete strobe.
REQ-009 The block SHALL have ports sram_rd_req and sram_wr_req, each output, 1, the backing-memory read and write requests.
REQ-010 The block SHALL have ports sram_addr, output, ADDR_W, and sram_wdata, output, WORD_W, the backing-memory address and write data.
REQ-011 The block SHALL have ports sram_rdata, input, 2*WORD_W, and sram_ready, input, 1, the returned block and memory done strobe.
REQ-012 The block SHALL have port flush, input, 1, a request to invalidate all lines.

Function
REQ-013 Address split SHALL be: addr[2] = word select (0 → low word); addr[3+INDEX_W-1:3] = index; top TAG_W bits = tag; addr[1:0] ignored.
REQ-014 A set SHALL hold 2 ways, each {valid, tag, block}, plus one LRU bit naming the way to replace next.
REQ-015 Hit SHALL mean: some way in the indexed set is valid with a matching tag; way 0 SHALL win if both ways match.
REQ-016 The FSM SHALL have states IDLE, FILL and WRITE.
REQ-017 In IDLE, a read hit SHALL drive rdata combinationally from the hit way, assert ready in the same cycle, and set LRU to the other way at the clock edge.
REQ-018 In IDLE, a read miss SHALL deassert ready and go to FILL.
REQ-019 In FILL, sram_rd_req SHALL be held with sram_addr = addr with bits [2:0] cleared. On the sram_ready cycle the block SHALL be written into the victim way at the edge, with valid set, the tag written and LRU set to the other way, and the FSM SHALL return to IDLE. The next cycle is then a hit and SHALL assert ready.
REQ-020 The victim way SHALL be way 0 if invalid, else way 1 if invalid, else the LRU way.
REQ-021 Writes SHALL be write-through, no-allocate. In IDLE, wr_en SHALL go to WRITE. In WRITE, sram_wr_req SHALL be held with sram_addr = addr and sram_wdata = wdata; on the sram_ready cycle ready SHALL be asserted and the FSM SHALL return to IDLE.
REQ-022 On a write hit, the selected word of the hit way SHALL be updated at that same edge and LRU set to the other way; a write miss SHALL leave the cache unchanged.
REQ-023 If rd_en and wr_en are both high in IDLE, the write SHALL take priority.
REQ-024 The CPU SHALL hold addr, wdata, rd_en and wr_en stable until ready; the block SHALL NOT check this.
REQ-025 ready SHALL be 0 in IDLE with no request, and in FILL; sram_rd_req and sram_wr_req SHALL never be high together.
REQ-026 flush in IDLE SHALL clear all valid and LRU bits at the edge and take priority over rd_en and wr_en that cycle; flush outside IDLE SHALL be ignored.
REQ-027 If sram_ready is high in IDLE, it SHALL be ignored.

Reset
REQ-028 rst SHALL force state IDLE and clear all valid and LRU bits.
REQ-029 During rst, ready, sram_rd_req and sram_wr_req SHALL be 0, and rdata and sram_addr SHALL be 0.
REQ-030 Reset during FILL or WRITE SHALL abort the transaction without writing the array.

Structure
REQ-031 A shared package SHALL hold the FSM state enum and the default values of ADDR_W, WORD_W and INDEX_W.
REQ-032 Each way SHALL be one instance of sub-module cache_way_array, holding valid, tag and data arrays with a synchronous write port, a combinational read port and an asynchronous clear.

Verification
REQ-033 The bench SHALL cover a cold read: read 0x0000_0104 with sram_rdata = {32'hBBBB_BBBB, 32'hAAAA_AAAA} and sram_ready after 3 cycles -> one sram_rd_req burst at 0x100; ready one cycle after the fill edge; rdata = 0xBBBB_BBBB.
REQ-034 The bench SHALL cover a conflict: read tags T1 then T2 at the same index, then read T1 -> all hits with no SRAM access; then read T3 -> T2's way is evicted (LRU), and re-reading T1 hits.
REQ-035 The bench SHALL cover a write hit: write 0x1234_5678 to a cached address 0x100 -> one sram_wr_req; ready on sram_ready; a following read returns 0x1234_5678 with no sram_rd_req.
REQ-036 The bench SHALL cover a write miss: write to an uncached address, then read it -> the read misses and issues sram_rd_req.
REQ-037 The bench SHALL cover flush and reset: fill 2 lines, pulse flush -> both re-reads miss. Separately, assert rst mid-FILL -> requests drop immediately, and the same read after reset misses again.

Source files
------------

// File: rtl/assoc_cache_ctrl_pkg.sv
// Shared types and default geometry for the 2-way associative cache controller.
package assoc_cache_ctrl_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int WORD_W_DEF  = 32;
  localparam int INDEX_W_DEF = 6;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE
  } state_t;

endpackage

// File: rtl/cache_way_array.sv
// One cache way: valid bits with async clear, tag and block arrays,
// synchronous write port and combinational read port.
module cache_way_array #(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 23,
  parameter int BLK_W   = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               we,
  input  logic [INDEX_W-1:0] idx,
  input  logic [TAG_W-1:0]   wtag,
  input  logic [BLK_W-1:0]   wblk,
  output logic               valid,
  output logic [TAG_W-1:0]   tag,
  output logic [BLK_W-1:0]   blk
);

  localparam int SETS = 1 << INDEX_W;

  logic [SETS-1:0]  vld;
  logic [TAG_W-1:0] tags [SETS];
  logic [BLK_W-1:0] data [SETS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
    end else if (clr) begin
      vld <= '0;
    end else if (we) begin
      vld[idx] <= 1'b1;
    end
  end

  // Payload arrays need no reset; valid gates every use.
  always_ff @(posedge clk) begin
    if (we) begin
      tags[idx] <= wtag;
      data[idx] <= wblk;
    end
  end

  assign valid = vld[idx];
  assign tag   = tags[idx];
  assign blk   = data[idx];

endmodule

// File: rtl/assoc_cache_ctrl.sv
// 2-way set-associative, write-through / no-allocate cache controller
// with LRU replacement and a whole-cache flush.
module assoc_cache_ctrl
  import assoc_cache_ctrl_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int WORD_W  = WORD_W_DEF,
  parameter int INDEX_W = INDEX_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd_en,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [WORD_W-1:0]   wdata,
  output logic [WORD_W-1:0]   rdata,
  output logic                ready,
  output logic                sram_rd_req,
  output logic                sram_wr_req,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [WORD_W-1:0]   sram_wdata,
  input  logic [2*WORD_W-1:0] sram_rdata,
  input  logic                sram_ready,
  input  logic                flush
);

  localparam int TAG_W = ADDR_W - 3 - INDEX_W;
  localparam int BLK_W = 2 * WORD_W;
  localparam int SETS  = 1 << INDEX_W;

  state_t state;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic               wsel;

  assign idx  = addr[3+INDEX_W-1:3];
  assign tag  = addr[ADDR_W-1:ADDR_W-TAG_W];
  assign wsel = addr[2];

  logic [1:0]       v;
  logic [1:0]       we;
  logic [TAG_W-1:0] t [2];
  logic [BLK_W-1:0] b [2];
  logic [SETS-1:0]  lru;

  logic             hit0, hit1, hit, hway, victim;
  logic             idle, clr, rd_hit, fill_we, wr_upd;
  logic [BLK_W-1:0] hblk, merged, wblk;
  logic [WORD_W-1:0] hword;

  assign hit0  = v[0] && (t[0] == tag);
  assign hit1  = v[1] && (t[1] == tag);
  assign hit   = hit0 | hit1;
  assign hway  = !hit0;
  assign hblk  = hway ? b[1] : b[0];
  assign hword = wsel ? hblk[BLK_W-1:WORD_W] : hblk[WORD_W-1:0];

  // Fill empty ways first, then fall back on LRU.
  assign victim = !v[0] ? 1'b0 : (!v[1] ? 1'b1 : lru[idx]);

  assign idle    = (state == IDLE);
  assign clr     = idle && flush;
  assign rd_hit  = idle && !flush && !wr_en && rd_en && hit;
  assign fill_we = (state == FILL) && sram_ready;
  assign wr_upd  = (state == WRITE) && sram_ready && hit;

  assign merged = wsel ? {wdata, hblk[WORD_W-1:0]}
                       : {hblk[BLK_W-1:WORD_W], wdata};
  assign wblk   = fill_we ? sram_rdata : merged;

  for (genvar w = 0; w < 2; w++) begin : g_way
    assign we[w] = (fill_we && (victim == 1'(w)))
                || (wr_upd && (hway == 1'(w)));

    cache_way_array #(
      .INDEX_W (INDEX_W),
      .TAG_W   (TAG_W),
      .BLK_W   (BLK_W)
    ) u_way (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .we    (we[w]),
      .idx   (idx),
      .wtag  (tag),
      .wblk  (wblk),
      .valid (v[w]),
      .tag   (t[w]),
      .blk   (b[w])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      lru   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (flush) begin
            lru <= '0;
          end else if (wr_en) begin
            state <= WRITE;
          end else if (rd_en) begin
            if (hit) lru[idx] <= ~hway;
            else     state    <= FILL;
          end
        end
        FILL: begin
          if (sram_ready) begin
            lru[idx] <= ~victim;
            state    <= IDLE;
          end
        end
        WRITE: begin
          if (sram_ready) begin
            if (hit) lru[idx] <= ~hway;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready = !rst
              && (rd_hit || ((state == WRITE) && sram_ready));
  assign rdata = (!rst && rd_hit) ? hword : '0;

  assign sram_rd_req = !rst && (state == FILL);
  assign sram_wr_req = !rst && (state == WRITE);

  always_comb begin
    sram_addr  = '0;
    sram_wdata = '0;
    if (sram_rd_req) begin
      sram_addr = {addr[ADDR_W-1:3], 3'b000};
    end else if (sram_wr_req) begin
      sram_addr  = addr;
      sram_wdata = wdata;
    end
  end

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Scoreboard bench for assoc_cache_ctrl with a 3-cycle backing-memory model.
module tb_assoc_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ready;
  logic        sram_rd_req;
  logic        sram_wr_req;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [63:0] sram_rdata = '0;
  logic        sram_ready = 1'b0;

  assoc_cache_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .rd_en       (rd_en),
    .wr_en       (wr_en),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .ready       (ready),
    .sram_rd_req (sram_rd_req),
    .sram_wr_req (sram_wr_req),
    .sram_addr   (sram_addr),
    .sram_wdata  (sram_wdata),
    .sram_rdata  (sram_rdata),
    .sram_ready  (sram_ready),
    .flush       (flush)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          wcnt = 0;
  logic [31:0] exp_q [$];
  logic [63:0] mem [logic [31:0]];

  function automatic logic [63:0] blk_of(input logic [31:0] a);
    logic [31:0] ba;
    ba = {a[31:3], 3'b000};
    if (mem.exists(ba)) return mem[ba];
    return {ba ^ 32'hCAFE_0004, ba ^ 32'hFACE_0000};
  endfunction

  task automatic check(input string tg, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tg, got, exp);
    end
  endtask

  // Backing memory: answers any request on its third cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sram_ready) begin
        sram_ready = 1'b0;
      end else if (sram_rd_req || sram_wr_req) begin
        wcnt++;
        if (wcnt == 3) begin
          wcnt = 0;
          sram_ready = 1'b1;
          if (sram_rd_req) sram_rdata = blk_of(sram_addr);
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  task automatic do_read(input logic [31:0] a, input bit miss,
                         input string tg);
    int          cyc;
    int          bursts;
    bit          prev;
    logic [63:0] bl;
    cyc = 0;
    bursts = 0;
    prev = 1'b0;
    bl = blk_of(a);
    exp_q.push_back(a[2] ? bl[63:32] : bl[31:0]);
    addr = a;
    rd_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cyc++;
      if (sram_rd_req && !prev) begin
        bursts++;
        check({tg, ".raddr"}, 64'(sram_addr), 64'({a[31:3], 3'b000}));
      end
      prev = sram_rd_req;
      check({tg, ".nowr"}, 64'(sram_wr_req), 64'd0);
      if (ready) break;
    end
    check({tg, ".rdy"}, 64'(ready), 64'd1);
    check({tg, ".data"}, 64'(rdata), 64'(exp_q.pop_front()));
    check({tg, ".burst"}, 64'(bursts), miss ? 64'd1 : 64'd0);
    check({tg, ".lat"}, 64'(cyc), miss ? 64'd5 : 64'd1);
    @(posedge clk);
    #1;
    rd_en = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input string tg);
    int          cyc;
    int          bursts;
    bit          prev;
    logic [63:0] bl;
    cyc = 0;
    bursts = 0;
    prev = 1'b0;
    bl = blk_of(a);
    if (a[2]) bl[63:32] = d;
    else      bl[31:0]  = d;
    mem[{a[31:3], 3'b000}] = bl;
    addr = a;
    wdata = d;
    wr_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cyc++;
      if (sram_wr_req && !prev) begin
        bursts++;
        check({tg, ".waddr"}, 64'(sram_addr), 64'(a));
        check({tg, ".wdata"}, 64'(sram_wdata), 64'(d));
      end
      prev = sram_wr_req;
      check({tg, ".nord"}, 64'(sram_rd_req), 64'd0);
      if (ready) break;
    end
    check({tg, ".rdy"}, 64'(ready), 64'd1);
    check({tg, ".burst"}, 64'(bursts), 64'd1);
    check({tg, ".lat"}, 64'(cyc), 64'd4);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mem[32'h0000_0100] = {32'hBBBB_BBBB, 32'hAAAA_AAAA};
    addr = 32'h0000_0104;
    rd_en = 1'b1;
    #12;
    check("rst.rdy", 64'(ready), 64'd0);
    check("rst.rreq", 64'(sram_rd_req), 64'd0);
    check("rst.wreq", 64'(sram_wr_req), 64'd0);
    check("rst.rdata", 64'(rdata), 64'd0);
    check("rst.saddr", 64'(sram_addr), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd_en = 1'b0;

    do_read(32'h0000_0104, 1'b1, "cold");

    do_read(32'h0000_1028, 1'b1, "t1");
    do_read(32'h0000_2028, 1'b1, "t2");
    do_read(32'h0000_1028, 1'b0, "t1h");
    do_read(32'h0000_2028, 1'b0, "t2h");
    do_read(32'h0000_1028, 1'b0, "t1h2");
    do_read(32'h0000_3028, 1'b1, "t3");
    do_read(32'h0000_1028, 1'b0, "t1h3");
    do_read(32'h0000_2028, 1'b1, "t2ev");

    do_write(32'h0000_0100, 32'h1234_5678, "wh");
    do_read(32'h0000_0100, 1'b0, "wh_rd");
    do_read(32'h0000_0104, 1'b0, "wh_rd1");

    do_write(32'h0000_4000, 32'hDEAD_BEEF, "wm");
    do_read(32'h0000_4000, 1'b1, "wm_rd");

    do_read(32'h0000_0200, 1'b1, "f1");
    do_read(32'h0000_0304, 1'b1, "f2");
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    do_read(32'h0000_0200, 1'b1, "f1r");
    do_read(32'h0000_0304, 1'b1, "f2r");

    addr = 32'h0000_0500;
    rd_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rf.req", 64'(sram_rd_req), 64'd1);
    rst = 1'b1;
    #1;
    check("rf.drop", 64'(sram_rd_req), 64'd0);
    check("rf.rdy", 64'(ready), 64'd0);
    check("rf.saddr", 64'(sram_addr), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd_en = 1'b0;
    do_read(32'h0000_0500, 1'b1, "rf_re");
    do_read(32'h0000_0104, 1'b1, "rf_cold");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
